// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
// Carries the ID/EX/MEM/WB hazard inputs and the stall/flush/forward outputs.
//
// Ports (all members are logic):
//   RsD, RtD            5   ID source registers
//   UseRsD, UseRtD      1   ID instruction reads Rs / Rt
//   RsE, RtE            5   EX source registers
//   WriteRegE/M/W       5   destination registers in EX / MEM / WB
//   RegWriteE/M/W       1   destination write enables in EX / MEM / WB
//   MemtoRegE           1   EX instruction is a load
//   BranchTakenE        1   branch resolved taken in EX
//   MdStartE            1   EX instruction is a multi-cycle mul/div
//   StallF, StallD      1   hold PC and IF/ID
//   FlushD, FlushE      1   clear IF/ID and ID/EX
//   ForwardAE/BE        2   EX operand selects
//   MdBusy              1   mul/div sequencer busy
//   StallCount          16  saturating stall event counter
//   FlushCount          16  saturating flush event counter
// Modports: master = pipeline side, slave = hazard controller side.

interface pipe_hazard_ctrl_if;

    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic        UseRsD;
    logic        UseRtD;
    logic [4:0]  RsE;
    logic [4:0]  RtE;
    logic [4:0]  WriteRegE;
    logic [4:0]  WriteRegM;
    logic [4:0]  WriteRegW;
    logic        RegWriteE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        MemtoRegE;
    logic        BranchTakenE;
    logic        MdStartE;

    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        MdBusy;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    modport master (
        output RsD, RtD, UseRsD, UseRtD,
        output RsE, RtE,
        output WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, BranchTakenE, MdStartE,
        input  StallF, StallD, FlushD, FlushE,
        input  ForwardAE, ForwardBE, MdBusy,
        input  StallCount, FlushCount
    );

    modport slave (
        input  RsD, RtD, UseRsD, UseRtD,
        input  RsE, RtE,
        input  WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, BranchTakenE, MdStartE,
        output StallF, StallD, FlushD, FlushE,
        output ForwardAE, ForwardBE, MdBusy,
        output StallCount, FlushCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control for the 5-stage pipeline,
// with a mul/div hold sequencer and saturating stall/flush event counters.
//
// Ports:
//   CLK        in   pipeline clock, all state on posedge
//   RSTn       in   synchronous active-low reset
//   hz         slave modport of pipe_hazard_ctrl_if (hazard inputs,
//              stall/flush/forward outputs, MdBusy, counters)
// Parameter MD_CYCLES (2..255): total stall cycles per mul/div op.

module pipe_hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    pipe_hazard_ctrl_if.slave    hz
);

    // First BUSY cycle loads MD_CYCLES-2 so that the start cycle plus
    // all BUSY cycles add up to MD_CYCLES stall cycles.
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t   state_q;
    md_state_t   state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;

    logic        hit_rs;
    logic        hit_rt;
    logic        lwstall;
    logic        md_stall;
    logic        stall_raw;
    logic        flush_raw;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // MEM result is younger than WB, so it takes precedence.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (dst_m != 5'd0) && (dst_m == src))
            sel = FWD_MEM;
        else if (wr_w && (dst_w != 5'd0) && (dst_w == src))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(hz.RsE,
                        hz.RegWriteM, hz.WriteRegM,
                        hz.RegWriteW, hz.WriteRegW);
        fwd_b = fwd_sel(hz.RtE,
                        hz.RegWriteM, hz.WriteRegM,
                        hz.RegWriteW, hz.WriteRegW);
    end

    always_comb begin
        hit_rs  = hz.UseRsD && (hz.RsD == hz.WriteRegE);
        hit_rt  = hz.UseRtD && (hz.RtD == hz.WriteRegE);
        lwstall = hz.MemtoRegE
               && hz.RegWriteE
               && (hz.WriteRegE != 5'd0)
               && (hit_rs || hit_rt);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A taken branch in EX squashes the op in EX, so it never starts the
    // sequencer. Once BUSY, further MdStartE pulses are ignored and a
    // branch flushes the front end without aborting the running op.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hz.MdStartE && !hz.BranchTakenE) begin
                    state_d = BUSY;
                    cnt_d   = MD_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0)
                    cnt_d = cnt_q - 8'd1;
                else
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        md_stall  = ((state_q == IDLE) && hz.MdStartE)
                 || (state_q == BUSY);
        stall_raw = (lwstall || md_stall) && !hz.BranchTakenE;
        flush_raw = hz.BranchTakenE;
    end

    // Reset forces both pipeline registers to flush and everything
    // else quiet, independent of whatever the inputs carry.
    always_comb begin
        hz.StallF     = 1'b0;
        hz.StallD     = 1'b0;
        hz.FlushD     = 1'b1;
        hz.FlushE     = 1'b1;
        hz.ForwardAE  = FWD_RF;
        hz.ForwardBE  = FWD_RF;
        hz.MdBusy     = 1'b0;
        if (RSTn) begin
            hz.StallF    = stall_raw;
            hz.StallD    = stall_raw;
            hz.FlushD    = flush_raw;
            hz.FlushE    = lwstall || md_stall || flush_raw;
            hz.ForwardAE = fwd_a;
            hz.ForwardBE = fwd_b;
            hz.MdBusy    = (state_q == BUSY);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall_raw && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_raw && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    always_comb begin
        hz.StallCount = stall_cnt_q;
        hz.FlushCount = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Inputs change 1ns after posedge; outputs are sampled at negedge.

module tb_pipe_hazard_ctrl;

    logic CLK;
    logic RSTn;
    int   checks;
    int   passes;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(
        .MD_CYCLES (4)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .hz   (hz_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_in();
        hz_if.RsD          = 5'd0;
        hz_if.RtD          = 5'd0;
        hz_if.UseRsD       = 1'b0;
        hz_if.UseRtD       = 1'b0;
        hz_if.RsE          = 5'd0;
        hz_if.RtE          = 5'd0;
        hz_if.WriteRegE    = 5'd0;
        hz_if.WriteRegM    = 5'd0;
        hz_if.WriteRegW    = 5'd0;
        hz_if.RegWriteE    = 1'b0;
        hz_if.RegWriteM    = 1'b0;
        hz_if.RegWriteW    = 1'b0;
        hz_if.MemtoRegE    = 1'b0;
        hz_if.BranchTakenE = 1'b0;
        hz_if.MdStartE     = 1'b0;
    endtask

    task automatic set_lu();
        hz_if.MemtoRegE = 1'b1;
        hz_if.RegWriteE = 1'b1;
        hz_if.WriteRegE = 5'd8;
        hz_if.RtD       = 5'd8;
        hz_if.UseRtD    = 1'b1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        RSTn   = 1'b0;
        clear_in();
        // forwarding match presented during reset must be masked
        hz_if.RsE       = 5'd5;
        hz_if.WriteRegM = 5'd5;
        hz_if.RegWriteM = 1'b1;
        hz_if.MdStartE  = 1'b1;
        mid();
        chk("rst_stalld", 16'(hz_if.StallD), 16'd0);
        chk("rst_flushd", 16'(hz_if.FlushD), 16'd1);
        chk("rst_flushe", 16'(hz_if.FlushE), 16'd1);
        chk("rst_fwda", 16'(hz_if.ForwardAE), 16'd0);
        chk("rst_busy", 16'(hz_if.MdBusy), 16'd0);
        tick();
        tick();
        RSTn = 1'b1;
        clear_in();
        mid();
        chk("rst_scnt", hz_if.StallCount, 16'd0);
        chk("rst_fcnt", hz_if.FlushCount, 16'd0);
        chk("idle_flushe", 16'(hz_if.FlushE), 16'd0);

        // forwarding priority
        hz_if.RsE       = 5'd5;
        hz_if.RtE       = 5'd5;
        hz_if.WriteRegM = 5'd5;
        hz_if.RegWriteM = 1'b1;
        hz_if.WriteRegW = 5'd5;
        hz_if.RegWriteW = 1'b1;
        #1;
        chk("fwd_a_mem", 16'(hz_if.ForwardAE), 16'd2);
        chk("fwd_b_mem", 16'(hz_if.ForwardBE), 16'd2);
        hz_if.RegWriteM = 1'b0;
        #1;
        chk("fwd_a_wb", 16'(hz_if.ForwardAE), 16'd1);
        chk("fwd_b_wb", 16'(hz_if.ForwardBE), 16'd1);
        hz_if.RegWriteM = 1'b1;
        hz_if.WriteRegM = 5'd0;
        hz_if.WriteRegW = 5'd0;
        hz_if.RsE       = 5'd0;
        hz_if.RtE       = 5'd0;
        #1;
        chk("fwd_a_r0", 16'(hz_if.ForwardAE), 16'd0);
        chk("fwd_b_r0", 16'(hz_if.ForwardBE), 16'd0);
        hz_if.RsE       = 5'd3;
        hz_if.RtE       = 5'd7;
        hz_if.WriteRegM = 5'd3;
        hz_if.WriteRegW = 5'd7;
        #1;
        chk("fwd_a_split", 16'(hz_if.ForwardAE), 16'd2);
        chk("fwd_b_split", 16'(hz_if.ForwardBE), 16'd1);
        clear_in();

        // load-use, one cycle
        tick();
        set_lu();
        mid();
        chk("lu_stallf", 16'(hz_if.StallF), 16'd1);
        chk("lu_stalld", 16'(hz_if.StallD), 16'd1);
        chk("lu_flushe", 16'(hz_if.FlushE), 16'd1);
        chk("lu_flushd", 16'(hz_if.FlushD), 16'd0);
        tick();
        clear_in();
        mid();
        chk("lu_after", 16'(hz_if.StallD), 16'd0);
        chk("lu_scnt", hz_if.StallCount, 16'd1);

        // load with no consumer, and load to r0
        tick();
        set_lu();
        hz_if.UseRtD = 1'b0;
        mid();
        chk("lu_nouse", 16'(hz_if.StallD), 16'd0);
        tick();
        set_lu();
        hz_if.WriteRegE = 5'd0;
        hz_if.RtD       = 5'd0;
        mid();
        chk("lu_r0", 16'(hz_if.StallD), 16'd0);
        tick();
        clear_in();
        mid();
        chk("lu_scnt2", hz_if.StallCount, 16'd1);

        // mul/div, MD_CYCLES = 4
        tick();
        hz_if.MdStartE = 1'b1;
        mid();
        chk("md_t0_stall", 16'(hz_if.StallD), 16'd1);
        chk("md_t0_busy", 16'(hz_if.MdBusy), 16'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            hz_if.MdStartE = 1'b0;
            mid();
            chk("md_stall", 16'(hz_if.StallD), 16'd1);
            chk("md_busy", 16'(hz_if.MdBusy), 16'd1);
        end
        tick();
        mid();
        chk("md_end_stall", 16'(hz_if.StallD), 16'd0);
        chk("md_end_busy", 16'(hz_if.MdBusy), 16'd0);
        chk("md_scnt", hz_if.StallCount, 16'd5);

        // branch
        tick();
        hz_if.BranchTakenE = 1'b1;
        mid();
        chk("br_flushd", 16'(hz_if.FlushD), 16'd1);
        chk("br_flushe", 16'(hz_if.FlushE), 16'd1);
        chk("br_stallf", 16'(hz_if.StallF), 16'd0);
        tick();
        clear_in();
        mid();
        chk("br_fcnt", hz_if.FlushCount, 16'd1);
        chk("br_after", 16'(hz_if.FlushD), 16'd0);

        // branch beats a simultaneous load-use
        tick();
        set_lu();
        hz_if.BranchTakenE = 1'b1;
        mid();
        chk("brlu_stallf", 16'(hz_if.StallF), 16'd0);
        chk("brlu_flushe", 16'(hz_if.FlushE), 16'd1);
        tick();
        clear_in();
        mid();
        chk("brlu_fcnt", hz_if.FlushCount, 16'd2);
        chk("brlu_scnt", hz_if.StallCount, 16'd5);

        // MdStartE while BUSY is ignored
        tick();
        hz_if.MdStartE = 1'b1;
        tick();
        tick();
        tick();
        hz_if.MdStartE = 1'b0;
        mid();
        chk("md_rst_ign", 16'(hz_if.MdBusy), 16'd1);
        tick();
        mid();
        chk("md_ign_end", 16'(hz_if.MdBusy), 16'd0);
        chk("md_ign_scnt", hz_if.StallCount, 16'd9);

        // branch while BUSY flushes but keeps the op running
        tick();
        hz_if.MdStartE = 1'b1;
        tick();
        hz_if.MdStartE = 1'b0;
        tick();
        hz_if.BranchTakenE = 1'b1;
        mid();
        chk("mdbr_stalld", 16'(hz_if.StallD), 16'd0);
        chk("mdbr_flushd", 16'(hz_if.FlushD), 16'd1);
        chk("mdbr_busy", 16'(hz_if.MdBusy), 16'd1);
        tick();
        hz_if.BranchTakenE = 1'b0;
        mid();
        chk("mdbr_busy3", 16'(hz_if.MdBusy), 16'd1);
        chk("mdbr_stall3", 16'(hz_if.StallD), 16'd1);
        tick();
        mid();
        chk("mdbr_idle", 16'(hz_if.MdBusy), 16'd0);
        chk("mdbr_scnt", hz_if.StallCount, 16'd12);
        chk("mdbr_fcnt", hz_if.FlushCount, 16'd3);

        // reset in the middle of an op
        tick();
        hz_if.MdStartE = 1'b1;
        tick();
        hz_if.MdStartE = 1'b0;
        tick();
        RSTn = 1'b0;
        mid();
        chk("mdrst_busy", 16'(hz_if.MdBusy), 16'd0);
        chk("mdrst_stall", 16'(hz_if.StallD), 16'd0);
        tick();
        RSTn = 1'b1;
        mid();
        chk("mdrst_busy2", 16'(hz_if.MdBusy), 16'd0);
        chk("mdrst_stall2", 16'(hz_if.StallD), 16'd0);
        chk("mdrst_scnt", hz_if.StallCount, 16'd0);
        chk("mdrst_fcnt", hz_if.FlushCount, 16'd0);
        tick();
        mid();
        chk("mdrst_busy3", 16'(hz_if.MdBusy), 16'd0);

        // stall counter saturation
        tick();
        set_lu();
        repeat (70000) tick();
        mid();
        chk("sat_scnt", hz_if.StallCount, 16'hFFFF);
        tick();
        clear_in();
        tick();
        mid();
        chk("sat_hold", hz_if.StallCount, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It produces the stall and flush controls for the IF/ID and ID/EX pipeline registers and the EX-stage forwarding selects. It also runs a counter FSM that holds the front of the pipeline while a multi-cycle mul/div operation completes. It keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- MD_CYCLES, 4, total stall cycles per mul/div op; legal range 2..255.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RSTn  in  1  reset, synchronous, active-low.
- RsD, RtD  in  5  source register numbers of the instruction in ID.
- UseRsD, UseRtD  in  1  ID instruction actually reads Rs / Rt.
- RsE, RtE  in  5  source register numbers of the instruction in EX.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register numbers in EX / MEM / WB.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables in EX / MEM / WB.
- MemtoRegE  in  1  EX instruction is a load.
- BranchTakenE  in  1  branch resolved taken in EX.
- MdStartE  in  1  EX instruction is a multi-cycle mul/div.
- StallF, StallD  out  1  hold the PC and the IF/ID register.
- FlushD, FlushE  out  1  clear the IF/ID and ID/EX registers at the next edge.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- MdBusy  out  1  FSM is in BUSY.
- StallCount, FlushCount  out  16  saturating event counters.

## Operation
Forwarding (combinational), shown for ForwardAE; ForwardBE uses RtE:
- 10 if RegWriteM, WriteRegM!=0 and WriteRegM==RsE.
- Else 01 if RegWriteW, WriteRegW!=0 and WriteRegW==RsE.
- Else 00.
- MEM wins over WB when both match.

Load-use detect (combinational):
- lwstall = MemtoRegE & RegWriteE & (WriteRegE!=0) & ((UseRsD & RsD==WriteRegE) | (UseRtD & RtD==WriteRegE)).
- Register 0 never triggers a stall.

Mul/div FSM, states IDLE and BUSY, with an 8-bit down-counter cnt:
- IDLE, MdStartE=1: go to BUSY, cnt <= MD_CYCLES-2.
- BUSY, cnt!=0: cnt <= cnt-1.
- BUSY, cnt==0: go to IDLE.
- md_stall = (IDLE & MdStartE) | BUSY.
- The mul/div op itself advances to MEM; its result is owned by the mul/div unit, not by this block.

Control outputs (combinational):
- StallF = StallD = (lwstall | md_stall) & ~BranchTakenE.
- FlushE = lwstall | md_stall | BranchTakenE.
- FlushD = BranchTakenE.
- MdBusy = (state==BUSY).

Priority and boundary rules:
- Reset > branch > mul/div > load-use.
- A branch in EX excludes a load or mul/div in EX, so the redirect always wins over any stall.
- BranchTakenE or MdStartE asserted while BUSY is a protocol violation: MdStartE is ignored, and BranchTakenE still flushes but does not leave BUSY.

Counters:
- StallCount increments each cycle StallD=1.
- FlushCount increments each cycle FlushD=1.
- Both saturate at 0xFFFF and never wrap.

## Timing
- Forwarding selects and stall/flush outputs are same-cycle combinational from the inputs and the FSM state.
- A load-use hazard costs exactly 1 stall cycle.
- A mul/div op stalls StallF/StallD for exactly MD_CYCLES consecutive cycles: the MdStartE cycle plus MD_CYCLES-1 BUSY cycles.
- MdBusy is high for MD_CYCLES-1 cycles, starting the cycle after MdStartE.
- Counters update at the posedge following the qualifying cycle.
- While RSTn=0:
  - StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00, MdBusy=0.
  - At the edge: state <= IDLE, cnt <= 0, StallCount <= 0, FlushCount <= 0.
- Reset mid-BUSY returns to IDLE at the next edge; the op in progress is abandoned.

## Test plan
- Forwarding priority: RsE=5, RtE=5, WriteRegM=5/RegWriteM=1, WriteRegW=5/RegWriteW=1 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> 01. Set all destinations to 0 -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=8, RtD=8, UseRtD=1 for one cycle -> StallF=StallD=FlushE=1 that cycle only, StallCount=1. Repeat with UseRtD=0 -> no stall.
- Mul/div, MD_CYCLES=4: MdStartE pulse at cycle t -> StallD=1 for cycles t..t+3, MdBusy=1 for t+1..t+3, StallD=0 at t+4, StallCount=4.
- Branch: BranchTakenE=1 for one cycle -> FlushD=FlushE=1, StallF=0, FlushCount increments by 1.
- Reset mid-op: MdStartE at t, RSTn=0 at t+2 -> MdBusy=0 and StallD=0 from t+3 onward with RSTn high again, StallCount=0.
- Saturation: force 70000 load-use stall cycles -> StallCount holds 0xFFFF.
